tt_um_serial_add8: RTL

Bit-serial 8-bit adder tile that builds on our combinational half-adder cell. Two half-adder instances plus an OR form a 1-bit full adder, time-multiplexed over 8 clock cycles. Operands are loaded byte-wide through the dedicated inputs, added LSB-first, and the 8-bit sum is presented on the dedicated outputs with carry-out, overflow and handshake status on the bidirectional pins.

---
 rtl/tt_serial_pkg.sv | 31 +++
 rtl/ha_cell.sv | 19 +
 rtl/tt_um_serial_add8.sv | 129 ++++++++++++
 3 files changed

// File: rtl/tt_serial_pkg.sv
// rtl/tt_serial_pkg.sv - shared types and constants for the bit-serial 8-bit adder tile
//
// Purpose: FSM state encoding, operand width, and the bit positions of the
// control (uio_in) and status (uio_out) fields, plus the output-enable mask.
// Ports: none (package).

package tt_serial_pkg;

    localparam int WIDTH = 8;

    // uio_in control bit positions
    localparam int LOAD_A = 0;
    localparam int LOAD_B = 1;
    localparam int START  = 2;
    localparam int CIN    = 3;

    // uio_out status bit positions
    localparam int BUSY = 4;
    localparam int DONE = 5;
    localparam int COUT = 6;
    localparam int OVF  = 7;

    localparam logic [7:0] UIO_OE_MASK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/ha_cell.sv
// rtl/ha_cell.sv - combinational half-adder cell
//
// Purpose: one-bit half adder; two of these plus an OR make a full adder.
// Ports:
//   a, b : operand bits
//   s    : sum bit   (a ^ b)
//   c    : carry bit (a & b)

module ha_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/tt_um_serial_add8.sv
// rtl/tt_um_serial_add8.sv - bit-serial 8-bit adder tile, LSB-first over 8 cycles
//
// Purpose: operands are loaded byte-wide, then added one bit per enabled
// clock through a single full adder built from two ha_cell instances.
// Ports:
//   clk     : clock, rising edge
//   rst_n   : synchronous active-low reset, overrides ena
//   ena     : clock enable, all state holds when low
//   ui_in   : operand byte
//   uio_in  : control {ignored[7:4], cin, start, load_b, load_a}
//   uo_out  : sum register
//   uio_out : status {ovf, cout, done, busy, 4'b0}
//   uio_oe  : constant 8'hF0

module tt_um_serial_add8
    import tt_serial_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               cout_q, cout_d;
    logic               c7_q, c7_d;

    logic load_a, load_b, start, cin, any_load;
    logic s1, c1, s, c2, co;

    assign load_a   = uio_in[LOAD_A];
    assign load_b   = uio_in[LOAD_B];
    assign start    = uio_in[START];
    assign cin      = uio_in[CIN];
    assign any_load = load_a | load_b;

    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, uio_in[7:4]};

    // Full adder: first cell adds the operand bits, second folds in the carry.
    ha_cell u_ha0 (.a(a_q[0]), .b(b_q[0]), .s(s1), .c(c1));
    ha_cell u_ha1 (.a(s1),     .b(carry_q), .s(s),  .c(c2));
    assign co = c1 | c2;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        cout_d  = cout_q;
        c7_d    = c7_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (any_load) begin
                    if (load_a) a_d = ui_in;
                    if (load_b) b_d = ui_in;
                    state_d = ST_IDLE;
                end else if (start) begin
                    carry_d = cin;
                    cnt_d   = 3'd0;
                    sum_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                carry_d = co;
                sum_d   = {s, sum_q[WIDTH-1:1]};
                // Rotate so the operands are intact after a full pass,
                // allowing a restart from DONE on the same values.
                a_d     = {a_q[0], a_q[WIDTH-1:1]};
                b_d     = {b_q[0], b_q[WIDTH-1:1]};
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    c7_d    = carry_q;
                    cout_d  = co;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= 3'd0;
            cout_q  <= 1'b0;
            c7_q    <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            cout_q  <= cout_d;
            c7_q    <= c7_d;
        end
    end

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_comb begin
        uio_out       = 8'h00;
        uio_out[BUSY] = (state_q == ST_RUN);
        uio_out[DONE] = (state_q == ST_DONE);
        uio_out[COUT] = cout_q;
        uio_out[OVF]  = cout_q ^ c7_q;
    end

    assign uo_out = sum_q;
    assign uio_oe = UIO_OE_MASK;

endmodule
